serial_parity_rx_checker: RTL and testbench

//  Receives LSB-first serial frames of DATA_W data bits followed by one parity bit.

---
 rtl/serial_parity_rx_checker.sv | 131 +++++++++++++
 tb/tb_serial_parity_rx_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_rx_checker.sv
// serial_parity_rx_checker
//   Receives LSB-first serial frames of DATA_W data bits followed by one parity bit.
//   The frame is checked for odd or even parity (mode latched with the first bit).
//   The data word and the parity result are presented. Parity errors are counted in a
//   saturating counter, and frames that stall for TMO_CYC idle cycles are dropped.
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    in_bit is valid this cycle
//   in_bit      serial bit: data LSB first, parity bit last
//   mode_odd    1 = odd parity, 0 = even; sampled with the first bit of a frame
//   cnt_clr     synchronous clear of err_cnt (wins over an increment)
//   data_out    data word of the last completed frame
//   frame_done  1-cycle pulse: data_out/par_err updated
//   par_err     parity result of the last completed frame (1 = error), held
//   frame_abort 1-cycle pulse: frame dropped on timeout
//   err_cnt     saturating count of completed frames with par_err = 1
//   busy        1 while a frame is in progress
module serial_parity_rx_checker #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TMO_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              mode_odd,
    input  logic              cnt_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              par_err,
    output logic              frame_abort,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);

    localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned TmoW = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] data_q;
    logic [IdxW-1:0]   idx_q;
    logic [TmoW-1:0]   tmo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              acc_q;
    logic              mode_q;
    logic              done_q;
    logic              err_q;
    logic              abort_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;

            // Counter follows the frame_done pulse, so a clear in that cycle wins.
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (done_q && err_q && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end

            case (state_q)
                StIdle: begin
                    tmo_q <= '0;
                    if (in_valid) begin
                        shift_q[0] <= in_bit;
                        acc_q      <= in_bit;
                        mode_q     <= mode_odd;
                        idx_q      <= IdxW'(1);
                        state_q    <= (DATA_W == 1) ? StParity : StData;
                    end
                end
                StData, StParity: begin
                    if (in_valid) begin
                        tmo_q <= '0;
                        if (state_q == StData) begin
                            for (int unsigned i = 0; i < DATA_W; i++) begin
                                if (IdxW'(i) == idx_q) shift_q[i] <= in_bit;
                            end
                            acc_q <= acc_q ^ in_bit;
                            if (idx_q == IdxW'(DATA_W - 1)) begin
                                state_q <= StParity;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            // Even: error when the total XOR is 1; odd: error when it is 0.
                            data_q  <= shift_q;
                            err_q   <= acc_q ^ in_bit ^ mode_q;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end else if (tmo_q == TmoW'(TMO_CYC - 1)) begin
                        // This idle cycle is the TMO_CYC-th: drop the partial frame.
                        tmo_q   <= '0;
                        abort_q <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data_out    = data_q;
    assign frame_done  = done_q;
    assign par_err     = err_q;
    assign frame_abort = abort_q;
    assign err_cnt     = cnt_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_serial_parity_rx_checker.sv
// Directed bench for serial_parity_rx_checker: DATA_W=4/CNT_W=2/TMO_CYC=3 instance plus a
// DATA_W=1 instance. Inputs change 1 time unit after the rising edge, outputs are sampled there.
module tb_serial_parity_rx_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_bit, mode_odd, cnt_clr;
    logic [3:0] data_out;
    logic       frame_done, par_err, frame_abort, busy;
    logic [1:0] err_cnt;

    logic       in_valid1, in_bit1, mode_odd1;
    logic [0:0] data_out1;
    logic       frame_done1, par_err1, frame_abort1, busy1;
    logic [1:0] err_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_parity_rx_checker #(.DATA_W(4), .CNT_W(2), .TMO_CYC(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .mode_odd(mode_odd),
        .cnt_clr(cnt_clr), .data_out(data_out), .frame_done(frame_done), .par_err(par_err),
        .frame_abort(frame_abort), .err_cnt(err_cnt), .busy(busy)
    );

    serial_parity_rx_checker #(.DATA_W(1), .CNT_W(2), .TMO_CYC(3)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_bit(in_bit1), .mode_odd(mode_odd1),
        .cnt_clr(cnt_clr), .data_out(data_out1), .frame_done(frame_done1), .par_err(par_err1),
        .frame_abort(frame_abort1), .err_cnt(err_cnt1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        step(1);
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic m);
        mode_odd = m;
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        send_bit(p);
    endtask

    initial begin
        logic [4:0] vv;
        logic       mm;
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; mode_odd = 1'b0; cnt_clr = 1'b0;
        in_valid1 = 1'b0; in_bit1 = 1'b0; mode_odd1 = 1'b0;
        step(2);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_perr", 32'(par_err), 0);
        chk("rst_abort", 32'(frame_abort), 0);
        chk("rst_cnt", 32'(err_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_busy1", 32'(busy1), 0);
        rst = 1'b0;

        // 1: even mode, 1,0,1,1 then parity 1 -> total XOR 0, no error
        mode_odd = 1'b0;
        send_bit(1'b1);
        chk("t1_busy", 32'(busy), 1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        chk("t1_no_done_early", 32'(frame_done), 0);
        send_bit(1'b1);
        chk("t1_done", 32'(frame_done), 1);
        chk("t1_data", 32'(data_out), 32'hd);
        chk("t1_perr", 32'(par_err), 0);
        chk("t1_busy_end", 32'(busy), 0);
        step(1);
        chk("t1_done_pulse", 32'(frame_done), 0);
        chk("t1_cnt", 32'(err_cnt), 0);

        // 2: odd mode, same frame -> error
        send_frame(4'b1101, 1'b1, 1'b1);
        chk("t2_perr", 32'(par_err), 1);
        step(1);
        chk("t2_cnt", 32'(err_cnt), 1);

        // Sweep all {parity,data} in both modes, back-to-back
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 32; v++) begin
                vv = v[4:0];
                mm = m[0];
                send_frame(vv[3:0], vv[4], mm);
                chk("sw_done", 32'(frame_done), 1);
                chk("sw_data", 32'(data_out), 32'(vv[3:0]));
                chk("sw_perr", 32'(par_err), 32'((^vv) ^ mm));
            end
        end
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        chk("sw_clr", 32'(err_cnt), 0);

        // 3: back-to-back error frames; count saturates at 3; clear beats increment
        for (int k = 1; k <= 5; k++) begin
            send_frame(4'b0000, 1'b1, 1'b0);
            chk("t3_perr", 32'(par_err), 1);
            chk("t3_cnt", 32'(err_cnt), (k - 1 > 3) ? 3 : k - 1);
        end
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        chk("t3_clr", 32'(err_cnt), 0);
        step(1);
        chk("t3_clr_hold", 32'(err_cnt), 0);

        // 4: timeout abort after 3 idle cycles
        send_frame(4'b1010, 1'b1, 1'b0);
        step(1);
        chk("t4_pre_cnt", 32'(err_cnt), 1);
        send_bit(1'b1); send_bit(1'b1);
        step(2);
        chk("t4_no_abort", 32'(frame_abort), 0);
        chk("t4_busy_gap", 32'(busy), 1);
        step(1);
        chk("t4_abort", 32'(frame_abort), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_no_done", 32'(frame_done), 0);
        chk("t4_data", 32'(data_out), 32'ha);
        chk("t4_perr", 32'(par_err), 1);
        chk("t4_cnt", 32'(err_cnt), 1);
        step(1);
        chk("t4_abort_pulse", 32'(frame_abort), 0);
        // 2-cycle gap mid-frame completes normally: bits 0,1,(gap),1,0 parity 0
        mode_odd = 1'b0;
        send_bit(1'b0); send_bit(1'b1);
        step(2);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        chk("t4g_done", 32'(frame_done), 1);
        chk("t4g_abort", 32'(frame_abort), 0);
        chk("t4g_data", 32'(data_out), 32'h6);
        chk("t4g_perr", 32'(par_err), 0);

        // 5: mode toggled after first bit is ignored (even latched, total XOR 0)
        mode_odd = 1'b0;
        send_bit(1'b1);
        mode_odd = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        chk("t5_data", 32'(data_out), 32'h3);
        chk("t5_perr_even", 32'(par_err), 0);
        // odd latched, toggled to even
        mode_odd = 1'b1;
        send_bit(1'b1);
        mode_odd = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        chk("t5_perr_odd", 32'(par_err), 1);
        step(1);
        chk("t5_cnt", 32'(err_cnt), 2);
        // reset mid-frame
        send_bit(1'b1); send_bit(1'b0);
        rst = 1'b1;
        #1;
        chk("t5r_busy", 32'(busy), 0);
        chk("t5r_data", 32'(data_out), 0);
        chk("t5r_perr", 32'(par_err), 0);
        chk("t5r_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(4'b1001, 1'b0, 1'b1);
        chk("t5n_done", 32'(frame_done), 1);
        chk("t5n_data", 32'(data_out), 32'h9);
        chk("t5n_perr", 32'(par_err), 1);
        step(1);
        chk("t5n_cnt", 32'(err_cnt), 1);

        // 6: DATA_W=1, odd mode, data 1 parity 0 -> no error
        in_valid1 = 1'b1; in_bit1 = 1'b1; mode_odd1 = 1'b1;
        step(1);
        chk("t6_busy", 32'(busy1), 1);
        mode_odd1 = 1'b0;
        in_bit1 = 1'b0;
        step(1);
        in_valid1 = 1'b0;
        chk("t6_done", 32'(frame_done1), 1);
        chk("t6_data", 32'(data_out1), 1);
        chk("t6_perr", 32'(par_err1), 0);
        // even mode, data 1 parity 0 -> error
        in_valid1 = 1'b1; in_bit1 = 1'b1; mode_odd1 = 1'b0;
        step(1);
        in_bit1 = 1'b0;
        step(1);
        in_valid1 = 1'b0;
        chk("t6e_perr", 32'(par_err1), 1);
        step(1);
        chk("t6e_cnt", 32'(err_cnt1), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
